// File: rtl/serial_sub_pkg.sv
// Shared constants and FSM state encoding for the bit-serial subtractor.
package serial_sub_pkg;

   localparam int unsigned SUB_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout is the borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per cycle; done pulses with the result.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = SUB_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned   CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   sub_state_t       state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q;
   logic [CW-1:0]    cnt;
   logic             br_q;
   logic             d_bit, bout_bit;
   logic             last, accept;

   full_subtractor u_fs (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .bin  (br_q),
      .d    (d_bit),
      .bout (bout_bit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      last      = (cnt == LAST);
      accept    = 1'b0;
      case (state)
         IDLE: begin
            accept = start;
            if (start) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            accept    = start;
            state_nxt = start ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operands shift right each RUN cycle; difference bits fill a_q from the top,
   // so a_q[0]/b_q[0] on the last cycle are the original MSBs used for ovf.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         br_q   <= 1'b0;
         cnt    <= '0;
         diff   <= '0;
         borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf    <= 1'b0;
`endif
      end else if (accept) begin
         a_q  <= a;
         b_q  <= b;
         br_q <= 1'b0;
         cnt  <= '0;
      end else if (state == RUN) begin
         a_q  <= {d_bit, a_q[WIDTH-1:1]};
         b_q  <= {1'b0, b_q[WIDTH-1:1]};
         br_q <= bout_bit;
         cnt  <= last ? '0 : cnt + 1'b1;
         if (last) begin
            diff   <= {d_bit, a_q[WIDTH-1:1]};
            borrow <= bout_bit;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= (a_q[0] ^ b_q[0]) & (a_q[0] ^ d_bit);
`endif
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor with WIDTH=4.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [3:0] a = '0;
   logic [3:0] b = '0;
   logic       busy, done, borrow;
   logic [3:0] diff;
`ifdef SERIAL_SUB_OVF_EN
   logic       ovf;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf    (ovf)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Caller is positioned at a negedge; start is raised here and dropped one cycle later.
   task automatic run_op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                         input logic [3:0] dexp, input logic bexp, input logic oexp);
      int lat = 0;
      a = av; b = bv; start = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1) begin
            start = 1'b0;
            a = ~av;
            b = ~bv;
            check({tag, "_busy"}, 32'(busy), 32'd1);
         end
         if (done) begin
            lat = i;
            break;
         end
      end
      check({tag, "_lat"}, 32'(lat), 32'd5);
      check({tag, "_diff"}, 32'(diff), 32'(dexp));
      check({tag, "_borrow"}, 32'(borrow), 32'(bexp));
`ifdef SERIAL_SUB_OVF_EN
      check({tag, "_ovf"}, 32'(ovf), 32'(oexp));
`else
      if (oexp === 1'bx) $display("unexpected ovf expectation in %s", tag);
`endif
      @(negedge clk);
      check({tag, "_done_off"}, 32'(done), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int ndone;

      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_borrow", 32'(borrow), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op("ff_ff", 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0);
      run_op("0_1",   4'b0000, 4'b0001, 4'b1111, 1'b1, 1'b0);
      run_op("a_3",   4'b1010, 4'b0011, 4'b0111, 1'b0, 1'b1);

      // Second start while running must be ignored.
      ndone = 0;
      a = 4'b0101; b = 4'b0001; start = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
         if (i == 2) begin a = 4'b1111; b = 4'b0000; start = 1'b1; end
         if (i == 3) start = 1'b0;
         if (done) begin
            ndone++;
            check("ign_pos", 32'(i), 32'd5);
            check("ign_diff", 32'(diff), 32'b0100);
            check("ign_borrow", 32'(borrow), 32'd0);
         end
      end
      check("ign_ndone", 32'(ndone), 32'd1);

      // Reset during the second RUN cycle.
      a = 4'b1001; b = 4'b0010; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_diff", 32'(diff), 32'd0);
      check("abort_borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      check("abort_ovf", 32'(ovf), 32'd0);
`endif
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_nodone", 32'(done), 32'd0);
      end
      rst = 1'b0;
      run_op("post_rst", 4'b0110, 4'b0010, 4'b0100, 1'b0, 1'b0);

      // Start held high: back-to-back operations, done every 5th cycle.
      ndone = 0;
      a = 4'b1000; b = 4'b0001; start = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            check("hold_pos", 32'(i % 5), 32'd0);
            check("hold_diff", 32'(diff), 32'b0111);
            check("hold_borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
            check("hold_ovf", 32'(ovf), 32'd1);
`endif
         end
      end
      check("hold_ndone", 32'(ndone), 32'd3);
      start = 1'b0;
      @(negedge clk);
      check("hold_idle", 32'(busy), 32'd0);
      check("hold_diff_kept", 32'(diff), 32'b0111);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand and difference width in bits (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a subtraction, sampled on a clk edge.
REQ-005 SHALL have port a, input, WIDTH bits: minuend.
REQ-006 SHALL have port b, input, WIDTH bits: subtrahend.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-009 SHALL have port diff, output, WIDTH bits: result, a - b modulo 2^WIDTH.
REQ-010 SHALL have port borrow, output, 1 bit: high when the unsigned a is less than the unsigned b.
REQ-011 SHALL have port ovf, output, 1 bit, present only when the configuration macro is defined (see REQ-026).

Function
REQ-012 SHALL implement three states:
- IDLE: waiting for start.
- RUN: processing one bit per cycle.
- DONE: single-cycle result pulse.
REQ-013 SHALL latch a and b, clear the internal borrow and clear the bit counter on any edge where start=1 and the state is IDLE or DONE, then enter RUN.
REQ-014 SHALL process bit i (i = 0 .. WIDTH-1, LSB first) on each RUN edge:
- d_i = a_i ^ b_i ^ br
- br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
REQ-015 SHALL leave RUN for DONE on the edge that processes bit WIDTH-1.
- done is high exactly WIDTH cycles after the edge that accepted start.
REQ-016 SHALL update diff and borrow only on entry to DONE, and hold them stable until the next entry to DONE or a reset.
REQ-017 SHALL assert done for exactly one cycle (state DONE).
- Next state is RUN if start=1 on that edge, otherwise IDLE.
REQ-018 SHALL assert busy only in state RUN.
REQ-019 SHALL ignore start while in RUN, with no effect on the latched operands or the result.
REQ-020 SHALL ignore changes on a and b after the accepting edge.

Reset
REQ-021 SHALL, while rst=1, immediately force:
- state IDLE;
- busy=0, done=0;
- diff=0, borrow=0, ovf=0;
- counter, latched operands and internal borrow to 0.
REQ-022 SHALL abort any operation in progress on reset, discard the partial result, and not produce a done pulse for it.
REQ-023 SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-024 SHALL gate the signed-overflow feature with macro SERIAL_SUB_OVF_EN.
REQ-025 SHALL, with SERIAL_SUB_OVF_EN defined, set ovf on entry to DONE to (a_msb ^ b_msb) & (a_msb ^ diff_msb), using the latched operands.
- ovf holds and resets like diff.
REQ-026 SHALL, without SERIAL_SUB_OVF_EN, omit the ovf port and its register entirely; all other behaviour is unchanged.

Structure
REQ-027 SHALL take the state encoding (IDLE, RUN, DONE) and the default WIDTH constant from shared package serial_sub_pkg.
REQ-028 SHALL instantiate one combinational sub-module, full_subtractor, with:
- inputs: a, b, bin (1 bit each);
- outputs: d, bout (1 bit each).
REQ-029 SHALL size the bit counter as ceil(log2(WIDTH)) bits and wrap it to 0 on every accepted start.

Verification
REQ-030 SHALL cover, with WIDTH=4:
- a=1111, b=1111, start one cycle -> done 4 cycles later; diff=0000, borrow=0, ovf=0.
- a=0000, b=0001 -> diff=1111, borrow=1, ovf=0.
- a=1010, b=0011 -> diff=0111, borrow=0, ovf=1.
- start with a=0101, b=0001; pulse start again with a=1111, b=0000 two cycles later -> single done; diff=0100.
- rst asserted in the 2nd RUN cycle -> all outputs 0 immediately, no done; next start with 0110-0010 -> diff=0100.
- start held high through DONE with a=1000, b=0001 -> done pulses every 5th cycle; diff=0111, ovf=1 each time.
